// File: rtl/lstm_gate_scheduler_pkg.sv
// Shared definitions for the LSTM gate scheduler: gate codes, FSM states and
// default fixed-point geometry.
package lstm_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/lstm_gate_scheduler_cma.sv
// ConcatMultAdd datapath: res = ((W0*x)>>>FW) + ((W1*h)>>>FW) + b, wrapped to
// DATA_WIDTH bits. Purely combinational; the caller registers the result.
module concat_mult_add #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_h,
    input  logic [DATA_WIDTH-1:0] i_w0,
    input  logic [DATA_WIDTH-1:0] i_w1,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_res
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] w_x_ext;
    logic signed [PW-1:0] w_h_ext;
    logic signed [PW-1:0] w_w0_ext;
    logic signed [PW-1:0] w_w1_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod0;
    logic signed [PW-1:0] w_prod1;
    logic signed [PW-1:0] w_p1;
    logic signed [PW-1:0] w_p2;
    logic signed [PW-1:0] w_sum;
    logic                 w_unused_hi;

    assign w_x_ext  = {{DATA_WIDTH{i_x[DATA_WIDTH-1]}},  i_x};
    assign w_h_ext  = {{DATA_WIDTH{i_h[DATA_WIDTH-1]}},  i_h};
    assign w_w0_ext = {{DATA_WIDTH{i_w0[DATA_WIDTH-1]}}, i_w0};
    assign w_w1_ext = {{DATA_WIDTH{i_w1[DATA_WIDTH-1]}}, i_w1};
    assign w_b_ext  = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}},  i_b};

    // Full-width products are exact; the arithmetic shift floors toward -inf.
    assign w_prod0 = w_w0_ext * w_x_ext;
    assign w_prod1 = w_w1_ext * w_h_ext;
    assign w_p1    = w_prod0 >>> FRACT_WIDTH;
    assign w_p2    = w_prod1 >>> FRACT_WIDTH;
    assign w_sum   = w_p1 + w_p2 + w_b_ext;

    // Dropping the upper half gives two's-complement wrap without saturation.
    assign o_res       = w_sum[DATA_WIDTH-1:0];
    assign w_unused_hi = ^w_sum[PW-1:DATA_WIDTH];

endmodule

// File: rtl/lstm_gate_scheduler.sv
// Time-multiplexes one ConcatMultAdd across all (unit, gate) pairs of a timestep
// and streams the pre-activation results over a valid/ready handshake.
module lstm_gate_scheduler
    import lstm_pkg::*;
#(
    parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter  int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter  int NUM_UNITS   = 8,
    localparam int UW          = $clog2(NUM_UNITS),
    localparam int AW          = $clog2(4 * NUM_UNITS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_x_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wt_rd_en,
    output logic [AW-1:0]         o_wt_addr,
    output logic [UW-1:0]         o_h_addr,
    input  logic [DATA_WIDTH-1:0] i_w0_rd,
    input  logic [DATA_WIDTH-1:0] i_w1_rd,
    input  logic [DATA_WIDTH-1:0] i_b_rd,
    input  logic [DATA_WIDTH-1:0] i_h_rd,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic [1:0]            o_res_gate,
    output logic [UW-1:0]         o_res_unit,
    output logic                  o_res_last
);

    state_t                r_state;
    state_t                w_state_next;
    logic [UW-1:0]         r_unit;
    logic [1:0]            r_gate;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [1:0]            r_res_gate;
    logic [UW-1:0]         r_res_unit;
    logic                  r_res_last;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_last;
    logic                  w_accept_start;
    logic                  w_advance;

    assign w_last = (r_unit == UW'(NUM_UNITS - 1)) && (r_gate == GATE_O);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_advance      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept_start = 1'b1;
                    w_state_next   = ST_FETCH;
                end
            end
            ST_FETCH:   w_state_next = ST_COMPUTE;
            ST_COMPUTE: w_state_next = ST_OUTPUT;
            ST_OUTPUT: begin
                if (i_res_ready) begin
                    if (r_res_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Counters walk unit-major, gate-minor; they stop on the last element so
    // the final result's tags stay meaningful until the next start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_unit <= '0;
            r_gate <= '0;
        end else if (w_accept_start) begin
            r_x    <= i_x_in;
            r_unit <= '0;
            r_gate <= GATE_I;
        end else if (w_advance) begin
            if (r_gate == GATE_O) begin
                r_gate <= GATE_I;
                r_unit <= r_unit + 1'b1;
            end else begin
                r_gate <= r_gate + 1'b1;
            end
        end
    end

    concat_mult_add #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_cma (
        .i_x   (r_x),
        .i_h   (i_h_rd),
        .i_w0  (i_w0_rd),
        .i_w1  (i_w1_rd),
        .i_b   (i_b_rd),
        .o_res (w_res)
    );

    // Memory data is only valid in COMPUTE; capturing there keeps res_* frozen
    // for the whole OUTPUT stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_data <= '0;
            r_res_gate <= '0;
            r_res_unit <= '0;
            r_res_last <= 1'b0;
        end else if (r_state == ST_COMPUTE) begin
            r_res_data <= w_res;
            r_res_gate <= r_gate;
            r_res_unit <= r_unit;
            r_res_last <= w_last;
        end
    end

    assign o_busy      = (r_state == ST_FETCH) || (r_state == ST_COMPUTE) ||
                         (r_state == ST_OUTPUT);
    assign o_done      = (r_state == ST_DONE);
    assign o_wt_rd_en  = (r_state == ST_FETCH);
    assign o_wt_addr   = {r_unit, r_gate};
    assign o_h_addr    = r_unit;
    assign o_res_valid = (r_state == ST_OUTPUT);
    assign o_res_data  = r_res_data;
    assign o_res_gate  = r_res_gate;
    assign o_res_unit  = r_res_unit;
    assign o_res_last  = r_res_last;

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Self-checking bench for lstm_gate_scheduler: random weights/state against a
// real-arithmetic reference, directed math corners, backpressure and abort.
module tb_lstm_gate_scheduler;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int NU = 8;
    localparam int NE = 4 * NU;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] x_in = '0;
    logic          busy, done, wt_rd_en;
    logic [4:0]    wt_addr;
    logic [2:0]    h_addr;
    logic [DW-1:0] w0_rd, w1_rd, b_rd, h_rd;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_data;
    logic [1:0]    res_gate;
    logic [2:0]    res_unit;
    logic          res_last;

    logic [DW-1:0] w0_mem [NE];
    logic [DW-1:0] w1_mem [NE];
    logic [DW-1:0] b_mem  [NE];
    logic [DW-1:0] h_mem  [NU];
    logic [DW-1:0] got    [NE];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lstm_gate_scheduler #(
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW),
        .NUM_UNITS   (NU)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_x_in      (x_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_wt_rd_en  (wt_rd_en),
        .o_wt_addr   (wt_addr),
        .o_h_addr    (h_addr),
        .i_w0_rd     (w0_rd),
        .i_w1_rd     (w1_rd),
        .i_b_rd      (b_rd),
        .i_h_rd      (h_rd),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_gate  (res_gate),
        .o_res_unit  (res_unit),
        .o_res_last  (res_last)
    );

    // Weight/state memories with one-cycle read latency.
    always @(posedge clk) begin
        if (wt_rd_en) begin
            w0_rd <= w0_mem[wt_addr];
            w1_rd <= w1_mem[wt_addr];
            b_rd  <= b_mem[wt_addr];
            h_rd  <= h_mem[h_addr];
        end
    end

    // Reference: real-valued product, floored, summed, wrapped modulo 2^DW.
    function automatic logic [DW-1:0] golden(input logic [DW-1:0] w0, input logic [DW-1:0] x,
                                             input logic [DW-1:0] w1, input logic [DW-1:0] h,
                                             input logic [DW-1:0] b);
        int a0, a1, ax, ah, ab, p1, p2, s;
        a0 = int'($signed(w0));
        a1 = int'($signed(w1));
        ax = int'($signed(x));
        ah = int'($signed(h));
        ab = int'($signed(b));
        p1 = int'($floor(real'(a0 * ax) / (2.0 ** FW)));
        p2 = int'($floor(real'(a1 * ah) / (2.0 ** FW)));
        s  = p1 + p2 + ab;
        return s[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_wt_rd_en"},  {31'd0, wt_rd_en},  32'd0);
        chk({tag, "_wt_addr"},   {27'd0, wt_addr},   32'd0);
        chk({tag, "_h_addr"},    {29'd0, h_addr},    32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_data"},  {16'd0, res_data},  32'd0);
        chk({tag, "_res_gate"},  {30'd0, res_gate},  32'd0);
        chk({tag, "_res_unit"},  {29'd0, res_unit},  32'd0);
        chk({tag, "_res_last"},  {31'd0, res_last},  32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NE; i++) begin
            w0_mem[i] = DW'($urandom);
            w1_mem[i] = DW'($urandom);
            b_mem[i]  = DW'($urandom);
        end
        for (int i = 0; i < NU; i++) h_mem[i] = DW'($urandom);
    endtask

    // Runs one timestep from IDLE; called and returns on a falling edge.
    task automatic run_ts(input logic [DW-1:0] x, input int stall_pct, input bit exp_timing);
        int            cyc = 0;
        int            idx = 0;
        int            fetch_idx = 0;
        int            rd_count = 0;
        bit            stalled = 0;
        bit            finished = 0;
        bit            rdy;
        logic [DW-1:0] held_data;
        logic [1:0]    held_gate;
        logic [2:0]    held_unit;
        logic          held_last;
        logic [DW-1:0] exp_d;
        start     = 1'b1;
        x_in      = x;
        res_ready = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 3000 && !finished; t++) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 10);
            x_in  = DW'($urandom);
            if (cyc == 1) chk("fetch_cycle1_rd_en", {31'd0, wt_rd_en}, 32'd1);
            if (cyc == 3) chk("first_valid_cycle3", {31'd0, res_valid}, 32'd1);
            if (wt_rd_en) begin
                chk("wt_addr", {27'd0, wt_addr}, 32'(fetch_idx % NE));
                chk("h_addr", {29'd0, h_addr}, 32'((fetch_idx / 4) % NU));
                fetch_idx++;
                rd_count++;
            end
            if (res_valid) begin
                if (stalled) begin
                    chk("hold_data", {16'd0, res_data}, {16'd0, held_data});
                    chk("hold_tags", {26'd0, res_gate, res_unit, res_last},
                        {26'd0, held_gate, held_unit, held_last});
                end
                rdy = ($urandom_range(99) >= 32'(stall_pct));
                res_ready = rdy;
                if (rdy) begin
                    if (idx < NE) begin
                        exp_d = golden(w0_mem[idx], x, w1_mem[idx], h_mem[idx / 4], b_mem[idx]);
                        got[idx] = res_data;
                    end else begin
                        exp_d = '0;
                    end
                    chk($sformatf("res_data[%0d]", idx), {16'd0, res_data}, {16'd0, exp_d});
                    chk($sformatf("res_gate[%0d]", idx), {30'd0, res_gate}, 32'(idx % 4));
                    chk($sformatf("res_unit[%0d]", idx), {29'd0, res_unit}, 32'((idx / 4) % NU));
                    chk($sformatf("res_last[%0d]", idx), {31'd0, res_last}, {31'd0, (idx == NE - 1)});
                    idx++;
                end
                held_data = res_data;
                held_gate = res_gate;
                held_unit = res_unit;
                held_last = res_last;
                stalled   = !rdy;
            end else begin
                res_ready = 1'($urandom);
                stalled   = 1'b0;
            end
            if (done) begin
                chk("done_count", 32'(idx), 32'(NE));
                chk("rd_en_count", 32'(rd_count), 32'(NE));
                if (exp_timing) chk("done_cycle", 32'(cyc), 32'd97);
                start = 1'b1;
                @(negedge clk);
                chk("start_in_done_ignored", {30'd0, busy, done}, 32'd0);
                start    = 1'b0;
                finished = 1'b1;
            end
        end
        if (!finished) chk("timestep_timeout", 32'd0, 32'd1);
        $display("timestep x=%h stall=%0d: %0d results, %0d reads, %0d cycles",
                 x, stall_pct, idx, rd_count, cyc);
    endtask

    initial begin
        bit saw_done;

        rst_n = 1'b0;
        start = 1'b1;
        x_in  = 16'h1234;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("start_during_reset_ignored", {31'd0, busy}, 32'd0);

        fill_random();
        w0_mem[0] = 16'h0200; w1_mem[0] = 16'h0100; b_mem[0] = 16'h0040; h_mem[0] = 16'h0080;
        run_ts(16'h0100, 0, 1);
        chk("math_basic", {16'd0, got[0]}, 32'h0000_02C0);

        fill_random();
        w0_mem[0] = 16'hFFFF; w1_mem[0] = 16'h0000; b_mem[0] = 16'h0000;
        run_ts(16'h0001, 30, 0);
        chk("math_floor", {16'd0, got[0]}, 32'h0000_FFFF);

        fill_random();
        w0_mem[0] = 16'h7FFF; w1_mem[0] = 16'h7FFF; b_mem[0] = 16'h7FFF; h_mem[0] = 16'h7FFF;
        run_ts(16'h7FFF, 0, 1);
        chk("math_wrap", {16'd0, got[0]}, 32'h0000_7DFF);

        fill_random();
        run_ts(DW'($urandom), 0, 1);
        fill_random();
        run_ts(DW'($urandom), 45, 0);

        // Abort a timestep mid-flight with reset at cycle 40.
        fill_random();
        saw_done  = 1'b0;
        start     = 1'b1;
        x_in      = DW'($urandom);
        res_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            start     = 1'b0;
            res_ready = 1'($urandom);
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_idle", {30'd0, busy, done}, 32'd0);
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_ts(DW'($urandom), 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_gate_scheduler.md
# lstm_gate_scheduler

Sequences one shared ConcatMultAdd datapath across all four LSTM gates of every hidden unit for a single timestep. For each (unit, gate) pair it fetches W0/W1/b and h_prev, computes `W0*x + W1*h + b` in Q(DW-FW).FW, and streams the pre-activation results to the activation stage over a valid/ready handshake. It sits between the weight/state memories and the sigmoid/tanh + cell-update logic.

## Interface
- DATA_WIDTH, 16, operand/result width (signed fixed point)
- FRACT_WIDTH, 8, fractional bits
- NUM_UNITS, 8, hidden units per timestep (≥2)
- Derived: UW = clog2(NUM_UNITS), AW = clog2(4*NUM_UNITS)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin timestep; honoured only in IDLE
- x_in  in  DW  timestep input, sampled on accepted start
- busy  out  1  high in FETCH/COMPUTE/OUTPUT
- done  out  1  one-cycle pulse after last result accepted
- wt_rd_en  out  1  weight/state read strobe
- wt_addr  out  AW  weight address = unit*4 + gate
- h_addr  out  UW  h_prev address = unit
- w0_rd, w1_rd, b_rd  in  DW  weight data, valid cycle after wt_rd_en
- h_rd  in  DW  h_prev data, valid cycle after wt_rd_en
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  DW  pre-activation value
- res_gate  out  2  gate code of res_data
- res_unit  out  UW  unit index of res_data
- res_last  out  1  high with final element (unit N-1, gate 3)

## Operation
- States: IDLE, FETCH, COMPUTE, OUTPUT, DONE.
- IDLE: start=1 → latch x_in into x_reg, clear unit/gate counters, → FETCH.
- FETCH: wt_rd_en=1, wt_addr/h_addr from counters → COMPUTE.
- COMPUTE: memory data valid; drive internal datapath with (x_reg, h_rd, w0_rd, w1_rd, b_rd); register result, gate, unit, last flag → OUTPUT.
- OUTPUT: res_valid=1. On res_ready: if last → DONE, else advance counters → FETCH. Without res_ready hold all res_* stable.
- DONE: done=1, busy=0 → IDLE.
- Order: unit-major, gate-minor: (u0,i),(u0,f),(u0,g),(u0,o),(u1,i)…; gate codes i=0,f=1,g=2,o=3.
- Arithmetic: p1=(W0*x)>>>FW, p2=(W1*h)>>>FW on 2·DW-bit products (arithmetic shift, floor toward −∞); res = p1+p2+b truncated to DW, two's-complement wrap, no saturation.
- start outside IDLE ignored (including DONE); x_reg does not change mid-timestep.
- Reset (any time, including mid-timestep): state IDLE, counters 0, x_reg 0, all outputs 0 (busy, done, wt_rd_en, wt_addr, h_addr, res_*); no done pulse issued for aborted timestep.

## Timing
- Accepted start at edge 0 → FETCH cycle 1, COMPUTE cycle 2, res_valid cycle 3.
- With res_ready held high: 3 cycles/element; NUM_UNITS=8 → last OUTPUT cycle 96, done cycle 97, earliest next start accepted cycle 98.
- Each res_ready stall cycle adds one cycle; nothing else stalls.
- wt_rd_en is high exactly one cycle per element; memory read latency fixed at 1.

## Structure
- Shared package lstm_pkg: gate code constants (GATE_I/F/G/O), state enum, default DATA_WIDTH/FRACT_WIDTH.
- One sub-module: ConcatMultAdd instance, parameters passed through, fed combinationally in COMPUTE.

## Test plan
- Reset values: rst_n=0 → all outputs 0, state IDLE; start during reset ignored.
- Single element math: x=0x0100, h=0x0080, W0=0x0200, W1=0x0100, b=0x0040 → res_data=0x02C0.
- Floor/wrap: W0=0xFFFF, x=0x0001, W1=0, b=0 → res_data=0xFFFF; W0=0x7FFF, x=0x7FFF, W1=0x7FFF, h=0x7FFF, b=0x7FFF → wrapped value matching golden model.
- Full timestep, res_ready=1, NUM_UNITS=8: 32 results in unit-major/gate-minor order, wt_addr 0..31, res_last only on 32nd, done at cycle 97.
- Backpressure: random res_ready low periods → res_* stable while valid&!ready, no lost/duplicated elements, wt_rd_en count = 32.
- Abort: rst_n low at cycle 40, release, new start → restarts from unit 0 gate 0, no done before new timestep completes; start pulsed while busy has no effect.
